// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder sequencer: default sizes and the
// FSM state encoding used by the controller and exposed for debug.
package serial_add_ctrl_pkg;

    localparam int WIDTH_DEF = 4;   // operand/sum width = datapath register width
    localparam int CNT_W_DEF = 3;   // bit-counter width, 2**CNT_W must exceed WIDTH

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LD_A = 3'd2,
        LD_B = 3'd3,
        RUN  = 3'd4,
        CAPT = 3'd5,
        RESP = 3'd6
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bus of the serial adder sequencer.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the sender keeps valid and its payload stable until that edge.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;

    // Requester side: issues operands, consumes results
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/serial_add_ctrl_bit_counter.sv
// Counts the add cycles of one serial addition; term flags the last bit.
module serial_add_ctrl_bit_counter
    import serial_add_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);
    logic [CNT_W-1:0] count;

    // Clear has priority over enable so the count restarts at 0 for every op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the shift-register serial adder: accepts one operand pair,
// walks the datapath through clear, load A, load B and WIDTH add cycles,
// captures sum/carry and returns them on the response channel.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    serial_add_ctrl_if.slave bus,
    output logic [WIDTH-1:0] dp_in,
    output logic             dp_load1,
    output logic             dp_load2,
    output logic             dp_clr,
    output logic             dp_start,
    input  logic [WIDTH-1:0] dp_sum,
    input  logic             dp_cout,
    output logic             busy,
    output state_t           state_dbg
);
    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             rsp_valid_q;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_term;

    // Counter runs only in RUN and is held at 0 everywhere else
    assign cnt_en  = (state == RUN);
    assign cnt_clr = (state != RUN) || cnt_term;

    serial_add_ctrl_bit_counter #(
        .CNT_W (CNT_W),
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term)
    );

    // Sequencer FSM; every datapath strobe is registered so it is high for
    // exactly the cycle its state occupies
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            dp_in       <= '0;
            dp_load1    <= 1'b0;
            dp_load2    <= 1'b0;
            dp_clr      <= 1'b0;
            dp_start    <= 1'b0;
        end else begin
            dp_in    <= '0;
            dp_load1 <= 1'b0;
            dp_load2 <= 1'b0;
            dp_clr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_a   <= bus.req_a;
                        op_b   <= bus.req_b;
                        dp_clr <= 1'b1;
                        state  <= CLR;
                    end
                end
                CLR: begin
                    dp_in    <= op_a;
                    dp_load1 <= 1'b1;
                    state    <= LD_A;
                end
                LD_A: begin
                    dp_in    <= op_b;
                    dp_load2 <= 1'b1;
                    state    <= LD_B;
                end
                LD_B: begin
                    dp_start <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (cnt_term) begin
                        dp_start <= 1'b0;
                        state    <= CAPT;
                    end
                end
                CAPT: begin
                    rsp_sum_q   <= dp_sum;
                    rsp_cout_q  <= dp_cout;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    dp_start    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Ready only in IDLE and never while reset is asserted
    assign bus.req_ready = (state == IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with a behavioural shift-register serial adder
// datapath on the same clock. Inputs change 1 time unit after posedge;
// outputs are sampled on negedge.
module tb_serial_add_ctrl;
    import serial_add_ctrl_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] dp_in;
    logic         dp_load1;
    logic         dp_load2;
    logic         dp_clr;
    logic         dp_start;
    logic [W-1:0] dp_sum;
    logic         dp_cout;
    logic         busy;
    state_t       state_dbg;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dp_in     (dp_in),
        .dp_load1  (dp_load1),
        .dp_load2  (dp_load2),
        .dp_clr    (dp_clr),
        .dp_start  (dp_start),
        .dp_sum    (dp_sum),
        .dp_cout   (dp_cout),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- serial adder datapath model ----------------
    logic [W-1:0] dpa;
    logic [W-1:0] dpb;
    logic         dpc;
    logic         sbit;
    assign sbit    = dpa[0] ^ dpb[0] ^ dpc;
    assign dp_sum  = dpa;
    assign dp_cout = dpc;

    always @(posedge clk) begin
        if (dp_clr) begin
            dpa <= '0;
            dpb <= '0;
            dpc <= 1'b0;
        end else if (dp_load1) begin
            dpa <= dp_in;
        end else if (dp_load2) begin
            dpb <= dp_in;
        end else if (dp_start) begin
            dpc <= (dpa[0] & dpb[0]) | (dpc & (dpa[0] ^ dpb[0]));
            dpa <= {sbit, dpa[W-1:1]};
            dpb <= {dpb[0], dpb[W-1:1]};
        end
    end

    // ---------------- check bookkeeping ----------------
    int pass_cnt = 0;
    int total_cnt = 0;
    int viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    op_t          op_q[$];
    logic [W:0]   exp_q[$];

    // Reference: accepted request -> (W+1)-bit arithmetic sum; also tracks
    // which operands the loads must carry and the strobe rules
    always @(negedge clk) begin
        if (!reset) begin
            if ($countones({dp_clr, dp_load1, dp_load2, dp_start}) > 1) viol++;
            if (!dp_load1 && !dp_load2 && dp_in != '0) viol++;
            if (dp_load1) begin
                if (op_q.size() > 0) check("load_a_operand", 32'(dp_in), 32'(op_q[0].a));
                else viol++;
            end
            if (dp_load2) begin
                if (op_q.size() > 0) begin
                    check("load_b_operand", 32'(dp_in), 32'(op_q[0].b));
                    void'(op_q.pop_front());
                end else viol++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() > 0) check("scoreboard_sum", 32'({bus.rsp_cout, bus.rsp_sum}), 32'(exp_q.pop_front()));
                else viol++;
            end
            if (bus.req_valid && bus.req_ready) begin
                op_q.push_back('{bus.req_a, bus.req_b});
                exp_q.push_back((W+1)'(bus.req_a) + (W+1)'(bus.req_b));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] sum, output logic cout);
        int n;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_a = a;
        bus.req_b = b;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
        if (!bus.req_ready) timeout_fail("req_ready_wait");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a = W'($urandom);
        bus.req_b = W'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
        if (!bus.rsp_valid) timeout_fail("rsp_valid_wait");
        sum  = bus.rsp_sum;
        cout = bus.rsp_cout;
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] s;
        logic         c;
        logic [4:0]   tr;
        logic [4:0]   etr;
        int           n;

        vecs[0] = '{4'd4,  4'd3,  4'd7,  1'b0};
        vecs[1] = '{4'd15, 4'd1,  4'd0,  1'b1};
        vecs[2] = '{4'd9,  4'd9,  4'd2,  1'b1};
        vecs[3] = '{4'd0,  4'd0,  4'd0,  1'b0};
        vecs[4] = '{4'd15, 4'd15, 4'd14, 1'b1};
        vecs[5] = '{4'd8,  4'd8,  4'd0,  1'b1};
        vecs[6] = '{4'd5,  4'd10, 4'd15, 1'b0};
        vecs[7] = '{4'd7,  4'd9,  4'd0,  1'b1};

        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;

        // Reset then idle
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_strobes", 32'({dp_clr, dp_load1, dp_load2, dp_start}), 32'd0);
        check("reset_rsp", 32'({bus.rsp_valid, bus.rsp_cout, bus.rsp_sum}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dp_in", 32'(dp_in), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("idle_state", 32'(state_dbg), 32'(IDLE));

        // Single add with cycle-exact strobe trace
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_a = 4'd4;
        bus.req_b = 4'd3;
        @(negedge clk);
        check("single_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a = 4'd11;
        bus.req_b = 4'd2;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            tr  = {dp_clr, dp_load1, dp_load2, dp_start, bus.rsp_valid};
            etr = {k == 1, k == 2, k == 3, (k >= 4 && k <= 7), k == 9};
            check($sformatf("trace_edge%0d", k), 32'(tr), 32'(etr));
            if (k == 2) check("trace_dp_in_a", 32'(dp_in), 32'd4);
            if (k == 3) check("trace_dp_in_b", 32'(dp_in), 32'd3);
        end
        check("single_sum", 32'({bus.rsp_cout, bus.rsp_sum}), 32'd7);
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, s, c);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
        end

        // Backpressure with req_valid held high
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_a = 4'd2;
        bus.req_b = 4'd5;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
        @(posedge clk); #1;
        bus.req_a = 4'd1;
        bus.req_b = 4'd1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
        if (!bus.rsp_valid) timeout_fail("bp_rsp_wait");
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 32'({bus.rsp_valid, bus.req_ready, bus.rsp_cout, bus.rsp_sum}), 32'({1'b1, 1'b0, 1'b0, 4'd7}));
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_resp_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("bp_next_accepted", 32'({busy, dp_clr}), 32'd3);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
        if (!bus.rsp_valid) timeout_fail("bp_second_rsp_wait");
        check("bp_second_sum", 32'({bus.rsp_cout, bus.rsp_sum}), 32'd2);
        @(posedge clk); #1;

        // Reset on the second dp_start cycle
        bus.req_valid = 1'b1;
        bus.req_a = 4'd3;
        bus.req_b = 4'd4;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dp_start && n < 50);
        if (!dp_start) timeout_fail("start_wait");
        @(posedge clk); #1;
        check("midrun_second_start", 32'(dp_start), 32'd1);
        reset = 1'b1;
        #1;
        check("midrun_reset_state", 32'(state_dbg), 32'(IDLE));
        check("midrun_reset_strobes", 32'({dp_clr, dp_load1, dp_load2, dp_start, busy, bus.rsp_valid}), 32'd0);
        op_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrun_release_ready", 32'(bus.req_ready), 32'd1);
        run_op(4'd6, 4'd5, s, c);
        check("post_reset_sum", 32'({c, s}), 32'd11);

        // Randomized back-to-back operations
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            bus.req_valid = 1'b1;
            bus.req_a = W'($urandom_range(0, 15));
            bus.req_b = W'($urandom_range(0, 15));
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
            if (!bus.req_ready) timeout_fail("rand_accept_wait");
            if (i > 0) check("rand_throughput", 32'(n), 32'(W + 6));
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_exp_q", 32'(exp_q.size()), 32'd0);
        check("drain_op_q", 32'(op_q.size()), 32'd0);
        check("strobe_rules", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
